// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, WIDTH-bit binary -> DIGITS packed BCD.
// Ports: Clk, Reset_Clear (async low), Start, Bin_In -> Busy, Done (1-cycle), BCD_Out (held).
module bin2bcd_seq #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset_Clear,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin_In,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD_Out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   adj;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Add-3 on every digit >= 5; digits never exceed 9 here, so no carry.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        Done = (state_q == DONE);
        if (Start) begin
          bin_d   = Bin_In;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        Busy  = 1'b1;
        scr_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = {adj[BW-2:0], bin_q[WIDTH-1]};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BCD_Out = bcd_q;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter downstream of the accumulator register. It captures the 17-bit accumulated value (carry bit plus 16-bit sum) on a start pulse and converts it iteratively into six packed BCD digits. It holds the result for the six seven-segment hex drivers, so the running total shows in decimal instead of hex. Start is driven by the same one-shot load pulse that updates the accumulator register, delayed one cycle so the new register value is stable.

## Interface
- WIDTH, 17, binary input width; must satisfy 10^DIGITS > 2^WIDTH − 1
- DIGITS, 6, number of 4-bit BCD output digits
- Clk  input  1  system clock, all state on rising edge
- Reset_Clear  input  1  asynchronous, active-low reset
- Start  input  1  conversion request, sampled on rising edge
- Bin_In  input  WIDTH  unsigned binary value to convert
- Busy  output  1  high while a conversion is in progress
- Done  output  1  one-cycle pulse, high in the cycle after the result is written
- BCD_Out  output  4*DIGITS  packed BCD result; digit 0 = [3:0] (ones), digit 5 = [23:20]

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: Busy=0, Done=0. If Start=1 at an edge:
  - copy Bin_In into the internal binary shift register;
  - clear the internal BCD scratch register (4*DIGITS bits) and iteration counter;
  - go to SHIFT.
- SHIFT: Busy=1, Done=0. Each edge performs one iteration:
  - in the scratch register, add 3 to every digit ≥ 5 (all digits in parallel);
  - shift {scratch, binary} left by 1, so the binary MSB enters scratch bit 0;
  - increment the counter.
- SHIFT exit: on the edge performing iteration WIDTH (counter = WIDTH−1), write the post-shift scratch value to BCD_Out and go to DONE.
- DONE: Busy=0, Done=1 for exactly one cycle.
  - Start=1 at this edge starts a new conversion (capture as in IDLE, go to SHIFT).
  - Otherwise go to IDLE.
- BCD_Out changes only on the completing edge of a conversion. It holds its last value through later conversions until they complete; it never shows partial scratch contents.
- Start during SHIFT is ignored, not queued.
- Bin_In is sampled only at the capture edge; later changes do not affect the running conversion.
- Arithmetic: digit adjust is 4-bit add with no carry-out possible (digit ≤ 9 before adjust, ≤ 12 after). Every output digit is 0–9. Max input 131071 → BCD_Out = 24'h131071.
- Counter width ⌈log2(WIDTH+1)⌉; no wrap inside a conversion.

## Timing
- Reset (Reset_Clear=0, async, any time): state=IDLE, Busy=0, Done=0, BCD_Out=0, scratch=0, counter=0.
  - Reset mid-conversion aborts the conversion; no Done pulse.
  - Outputs leave reset values only after a full conversion following deassertion.
- Latency: capture at edge E0; iterations at edges E1..E17 (WIDTH=17). BCD_Out valid and Done=1 after E17; Done falls after E18.
- Busy=1 from after E0 through after E16; Busy=0 when Done=1.
- Throughput: back-to-back Start in the DONE cycle gives one result every WIDTH+1 cycles.
- Busy and Done are never high together.

## Test plan
- Reset then Start with Bin_In=0 → after 17 SHIFT cycles Done=1, BCD_Out=24'h000000; Busy was high exactly 17 cycles.
- Bin_In=17'h1FFFF, Start → BCD_Out=24'h131071. Bin_In=17'h0FFFF → 24'h065535. Bin_In=17'd9 → 24'h000009. Bin_In=17'd10 → 24'h000010.
- Start with 1234; change Bin_In to 0 and pulse Start at E5 → single Done at E17, BCD_Out=24'h001234; no second conversion starts.
- Start with 500; hold Start=1 through the DONE cycle with Bin_In=777 → first Done gives 24'h000500, next Done 18 cycles later gives 24'h000777.
- Result 24'h000042 held; start conversion of 99999; assert Reset_Clear=0 at E8 → immediately Busy=0, BCD_Out=0; no Done; after release, Start with 99999 → 24'h099999.
- Random sweep of 1000 values in 0..131071 against a reference model → every digit ≤ 9; Done is a one-cycle pulse with Busy=0.
